// File: rtl/wallace_mac_accumulator.sv
// wallace_mac_accumulator
//   Sequential signed multiply-accumulate stage. Operand pairs arrive over a
//   valid/ready handshake and are multiplied by a Wallace-tree 8x8 signed
//   multiplier. The registered product is added into a signed saturating
//   accumulator. After N_TERMS products the result is held on a valid/ready
//   output until it is consumed.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   START               begin a new dot product (honoured only in IDLE)
//   IN_VALID/IN_READY   operand handshake for A, B (signed 8-bit)
//   OUT_VALID/OUT_READY result handshake for ACC (signed ACC_W-bit)
//   SAT                 sticky saturation flag for the current dot product
//   BUSY                state is not IDLE

// Signed 8x8 multiplier: nine partial-product rows reduced by a 3:2 carry-save
// tree (9 -> 6 -> 4 -> 3 -> 2) followed by one carry-propagate add.
module wallace_multiplier_top (
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic [15:0] PRODUCT
);
   localparam int unsigned PW = 16;

   logic [PW-1:0] ext_a;
   logic [PW-1:0] pp [9];
   logic [PW-1:0] s1a, c1a, s1b, c1b, s1c, c1c;
   logic [PW-1:0] s2a, c2a, s2b, c2b;
   logic [PW-1:0] s3a, c3a;
   logic [PW-1:0] s4a, c4a;

   // 3:2 compressor on whole rows: {carry, sum}, carry pre-shifted by one.
   function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x,
                                           input logic [PW-1:0] y,
                                           input logic [PW-1:0] z);
      logic [PW-1:0] s;
      logic [PW-1:0] m;
      s = x ^ y ^ z;
      m = (x & y) | (x & z) | (y & z);
      return {m[PW-2:0], 1'b0, s};
   endfunction

   assign ext_a = {{8{A[7]}}, A};

   // Rows 0..6 are sign-extended A shifted by bit weight. The multiplier's sign
   // bit has weight -2^7, so row 7 is the inverted shifted A and row 8 adds the
   // two's-complement correction (0x7F fill of the inverted low bits plus one).
   always_comb begin
      for (int i = 0; i < 9; i++) pp[i] = '0;
      for (int i = 0; i < 7; i++) pp[i] = B[i] ? PW'(ext_a << i) : '0;
      pp[7] = B[7] ? PW'((~ext_a) << 7) : '0;
      pp[8] = B[7] ? 16'h0080 : '0;
   end

   assign {c1a, s1a} = csa(pp[0], pp[1], pp[2]);
   assign {c1b, s1b} = csa(pp[3], pp[4], pp[5]);
   assign {c1c, s1c} = csa(pp[6], pp[7], pp[8]);
   assign {c2a, s2a} = csa(s1a, c1a, s1b);
   assign {c2b, s2b} = csa(c1b, s1c, c1c);
   assign {c3a, s3a} = csa(s2a, c2a, s2b);
   assign {c4a, s4a} = csa(s3a, c3a, c2b);

   assign PRODUCT = s4a + c4a;
endmodule

module wallace_mac_accumulator #(
   parameter int unsigned N_TERMS = 8,
   parameter int unsigned ACC_W   = 24
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [7:0]       A,
   input  logic [7:0]       B,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [ACC_W-1:0] ACC,
   output logic             SAT,
   output logic             BUSY
);
   localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
   localparam int unsigned SUM_W = ACC_W + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] count;
   logic [15:0]      product;
   logic [15:0]      p_reg;
   logic             p_vld;
   logic [ACC_W-1:0] acc;
   logic             sat;
   logic             accept;
   logic             start_ok;
   logic             last_add;
   logic [SUM_W-1:0] sum;
   logic [ACC_W-1:0] acc_nxt;
   logic             ovf;

   wallace_multiplier_top u_mult (
      .A       (A),
      .B       (B),
      .PRODUCT (product)
   );

   // Handshake and status decode from registered state only.
   assign IN_READY  = (state == S_RUN) && (count < CNT_W'(N_TERMS));
   assign accept    = IN_VALID && IN_READY;
   assign start_ok  = (state == S_IDLE) && START;
   assign last_add  = p_vld && (count == CNT_W'(N_TERMS));
   assign OUT_VALID = (state == S_DONE);
   assign BUSY      = (state != S_IDLE);
   assign ACC       = acc;
   assign SAT       = sat;

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (START)     state_nxt = S_RUN;
         S_RUN:   if (last_add)  state_nxt = S_DONE;
         S_DONE:  if (OUT_READY) state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   // Saturating add of the registered product; overflow when the two top
   // bits of the one-bit-wider sum disagree.
   always_comb begin
      sum     = {acc[ACC_W-1], acc} + {{(ACC_W-15){p_reg[15]}}, p_reg};
      ovf     = sum[ACC_W] != sum[ACC_W-1];
      acc_nxt = sum[ACC_W-1:0];
      if (ovf) acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
   end

   // Datapath: product pipeline register, term count, accumulator.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         p_reg <= '0;
         p_vld <= 1'b0;
         count <= '0;
         acc   <= '0;
         sat   <= 1'b0;
      end else begin
         p_vld <= accept;
         if (accept) begin
            p_reg <= product;
            count <= count + CNT_W'(1);
         end
         if (p_vld) begin
            acc <= acc_nxt;
            if (ovf) sat <= 1'b1;
         end
         if (start_ok) begin
            count <= '0;
            acc   <= '0;
            sat   <= 1'b0;
            p_vld <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_wallace_mac_accumulator.sv
module tb_wallace_mac_accumulator;
   logic clk = 1'b0;
   logic rst;

   // 4-term, 24-bit instance
   logic        start, in_valid, out_ready;
   logic [7:0]  a, b;
   logic        in_ready, out_valid, sat, busy;
   logic [23:0] acc;

   // 8-term, 18-bit instance
   logic        start8, in_valid8, out_ready8;
   logic [7:0]  a8, b8;
   logic        in_ready8, out_valid8, sat8, busy8;
   logic [17:0] acc8;

   int checks   = 0;
   int failures = 0;
   int qa[$];
   int qb[$];

   always #5 clk = ~clk;

   wallace_mac_accumulator #(.N_TERMS(4), .ACC_W(24)) u_dut4 (
      .CLK(clk), .RST(rst), .START(start), .IN_VALID(in_valid), .IN_READY(in_ready),
      .A(a), .B(b), .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .ACC(acc), .SAT(sat), .BUSY(busy)
   );

   wallace_mac_accumulator #(.N_TERMS(8), .ACC_W(18)) u_dut8 (
      .CLK(clk), .RST(rst), .START(start8), .IN_VALID(in_valid8), .IN_READY(in_ready8),
      .A(a8), .B(b8), .OUT_VALID(out_valid8), .OUT_READY(out_ready8),
      .ACC(acc8), .SAT(sat8), .BUSY(busy8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: integer products summed one by one with clamping to w bits.
   function automatic longint model(input int xa[$], input int xb[$], input int w, output bit s);
      longint maxv, minv, r;
      maxv = (longint'(1) << (w - 1)) - 1;
      minv = -maxv - 1;
      r = 0;
      s = 1'b0;
      foreach (xa[i]) begin
         r = r + longint'(xa[i]) * longint'(xb[i]);
         if (r > maxv) begin r = maxv; s = 1'b1; end
         if (r < minv) begin r = minv; s = 1'b1; end
      end
      return r;
   endfunction

   // One full dot product on the 4-term instance using qa/qb.
   task automatic run4(input string tag, input int gap, input int hold, input bit abuse);
      longint ex;
      bit     exs;
      ex = model(qa, qb, 24, exs);
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_start got %b exp 1", tag, busy); end
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         a = 8'(qa[i]);
         b = 8'(qb[i]);
         if (abuse && i == 2) start = 1'b1;
         checks++;
         if (in_ready !== 1'b1) begin failures++; $display("FAIL %s in_ready_run term %0d got %b exp 1", tag, i, in_ready); end
         tick();
         start    = 1'b0;
         in_valid = 1'b0;
         if (i < 3) begin
            for (int g = 0; g < gap; g++) begin
               checks++;
               if (busy !== 1'b1 || out_valid !== 1'b0) begin
                  failures++; $display("FAIL %s gap_state busy=%b out_valid=%b exp 1/0", tag, busy, out_valid);
               end
               tick();
            end
         end
      end
      if (abuse) begin in_valid = 1'b1; a = 8'sd127; b = 8'sd127; end
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL %s after_last_accept in_ready=%b out_valid=%b exp 0/0", tag, in_ready, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || acc !== 24'(ex) || sat !== exs || in_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL %s done acc=%0d sat=%b ov=%b ir=%b busy=%b exp acc=%0d sat=%b ov=1 ir=0 busy=1",
                  tag, $signed(acc), sat, out_valid, in_ready, busy, ex, exs);
      end
      for (int h = 0; h < hold; h++) begin
         if (abuse && h == 0) start = 1'b1;
         tick();
         start = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || acc !== 24'(ex) || in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s hold acc=%0d ov=%b ir=%b busy=%b exp acc=%0d ov=1 ir=0 busy=1",
                     tag, $signed(acc), out_valid, in_ready, busy, ex);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (abuse) start = 1'b1;
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || acc !== 24'(ex) || sat !== exs) begin
         failures++;
         $display("FAIL %s consumed ov=%b busy=%b acc=%0d exp ov=0 busy=0 acc=%0d", tag, out_valid, busy, $signed(acc), ex);
      end
      if (abuse) begin
         tick();
         checks++;
         if (busy !== 1'b0) begin failures++; $display("FAIL %s start_at_consume got busy=%b exp 0", tag, busy); end
      end
   endtask

   // One full dot product on the 8-term instance using qa/qb.
   task automatic run8(input string tag);
      longint ex;
      bit     exs;
      ex = model(qa, qb, 18, exs);
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid8 = 1'b1;
         a8 = 8'(qa[i]);
         b8 = 8'(qb[i]);
         tick();
      end
      in_valid8 = 1'b0;
      tick();
      checks++;
      if (out_valid8 !== 1'b1 || acc8 !== 18'(ex) || sat8 !== exs) begin
         failures++;
         $display("FAIL %s acc=%0d sat=%b ov=%b exp acc=%0d sat=%b ov=1", tag, $signed(acc8), sat8, out_valid8, ex, exs);
      end
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if (in_ready !== 0 || out_valid !== 0 || acc !== 0 || sat !== 0 || busy !== 0 ||
          in_ready8 !== 0 || out_valid8 !== 0 || acc8 !== 0 || sat8 !== 0 || busy8 !== 0) begin
         failures++;
         $display("FAIL reset_values ir=%b ov=%b acc=%0d sat=%b busy=%b exp all 0", in_ready, out_valid, acc, sat, busy);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      qa = '{10, 5, -8, -10};
      qb = '{-1, 3, 6, 10};
      run4("basic", 0, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      qa = '{10, 5, -8, -10};
      qb = '{-1, 3, 6, 10};
      run4("backpressure", 2, 5, 1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         qa.delete();
         qb.delete();
         for (int i = 0; i < 4; i++) begin
            qa.push_back(int'($urandom_range(255)) - 128);
            qb.push_back(int'($urandom_range(255)) - 128);
         end
         run4("random4", int'($urandom_range(2)), int'($urandom_range(3)), 1'b0);
      end
   endtask

   task automatic test_protocol();
      longint prev;
      prev = longint'($signed(acc));
      in_valid = 1'b1;
      a = 8'sd100;
      b = 8'sd100;
      repeat (3) begin
         tick();
         checks++;
         if (in_ready !== 1'b0 || busy !== 1'b0 || longint'($signed(acc)) != prev) begin
            failures++;
            $display("FAIL idle_valid ir=%b busy=%b acc=%0d exp 0/0/%0d", in_ready, busy, $signed(acc), prev);
         end
      end
      // in_valid still high while START is applied; that pair must be ignored.
      qa = '{-7, 33, 120, -128};
      qb = '{9, -2, 7, 1};
      run4("protocol", 1, 2, 1'b1);
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; a = 8'sd50; b = 8'sd60;
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 0 || out_valid !== 0 || acc !== 0 || sat !== 0 || busy !== 0) begin
         failures++;
         $display("FAIL reset_mid ir=%b ov=%b acc=%0d sat=%b busy=%b exp all 0", in_ready, out_valid, $signed(acc), sat, busy);
      end
      #2;
      rst = 1'b0;
      tick();
      qa = '{5, 5, 5, 5};
      qb = '{3, 3, 3, 3};
      run4("after_reset", 0, 0, 1'b0);
      checks++;
      if (acc !== 24'd60) begin failures++; $display("FAIL after_reset_const got %0d exp 60", $signed(acc)); end
   endtask

   task automatic test_saturation();
      qa = '{-128, -128, -128, -128, -128, -128, -128, -128};
      qb = '{-128, -128, -128, -128, -128, -128, -128, -128};
      run8("sat_pos");
      checks++;
      if (acc8 !== 18'd131071 || sat8 !== 1'b1) begin
         failures++; $display("FAIL sat_pos_const got %0d sat=%b exp 131071 sat=1", $signed(acc8), sat8);
      end
      qb = '{127, 127, 127, 127, 127, 127, 127, 127};
      run8("sat_clear");
      checks++;
      if (acc8 !== 18'(-130048) || sat8 !== 1'b0) begin
         failures++; $display("FAIL sat_clear_const got %0d sat=%b exp -130048 sat=0", $signed(acc8), sat8);
      end
      qa = '{-128, 7, 0, 0, 0, 0, 0, 0};
      qb = '{1, 120, 0, 0, 0, 0, 0, 0};
      run8("edge_extremes");
      checks++;
      if (acc8 !== 18'd712) begin failures++; $display("FAIL edge_extremes_const got %0d exp 712", $signed(acc8)); end
      for (int r = 0; r < 6; r++) begin
         qa.delete();
         qb.delete();
         for (int i = 0; i < 8; i++) begin
            qa.push_back(int'($urandom_range(255)) - 128);
            qb.push_back((r % 2 == 0) ? int'($urandom_range(127, 100)) * ((qa[i] < 0) ? -1 : 1)
                                      : int'($urandom_range(255)) - 128);
         end
         run8("random8");
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 0; in_valid = 0; out_ready = 0; a = 0; b = 0;
      start8 = 0; in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0;
      test_reset();
      test_basic();
      test_backpressure();
      test_random();
      test_protocol();
      test_reset_mid();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
